pipe_hazard_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage MIPS pipeline. It generates the PC enable and the stall/flush controls for the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers. It resolves load-use hazards, taken branches/jumps resolved in ID, instruction- and data-memory wait states, and multiply/divide unit (MDU) occupancy via an internal busy timer. A flushed pipeline register loads NOP 32'h0000_0020.

---
 rtl/pipe_ctrl_pkg.sv | 28 ++
 rtl/mdu_busy_timer.sv | 76 +++++++
 rtl/pipe_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared constants and types for the pipeline hazard controller:
//   NOP_INST         instruction loaded by a flushed pipeline register
//   MDU_*_CYC_DEF    default multiply / divide latencies in cycles
//   REG_ZERO         architectural $zero register index
//   mdu_state_e      MDU busy-timer state encoding
//   reg_hit()        "instruction reads register r" helper
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam logic [31:0] NOP_INST        = 32'h0000_0020;
  localparam int          MDU_MUL_CYC_DEF = 4;
  localparam int          MDU_DIV_CYC_DEF = 32;
  localparam logic [4:0]  REG_ZERO        = 5'd0;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  // True when a source operand is actually read and names register r.
  function automatic logic reg_hit(input logic used, input logic [4:0] src,
                                   input logic [4:0] r);
    return used && (src == r);
  endfunction

endpackage

// File: rtl/mdu_busy_timer.sv
// -----------------------------------------------------------------------------
// mdu_busy_timer
// Tracks occupancy of the multiply/divide unit.
//   clk, rst_n  clock, asynchronous active-low reset
//   start       accepted MDU operation start (already qualified by the caller)
//   is_div      started operation is a divide (selects DIV latency)
//   busy        timer running (state BUSY)
//   done        one-cycle pulse on the final cycle of the operation
// A latency of 1 loads count 0: the timer stays IDLE and a pending flag
// produces the done pulse on the following cycle.
// -----------------------------------------------------------------------------
module mdu_busy_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYC = MDU_MUL_CYC_DEF,
  parameter int DIV_CYC = MDU_DIV_CYC_DEF,
  parameter int CNT_W   = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic done
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYC - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYC - 1);

  mdu_state_e       state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             pend_reg, pend_next;
  logic [CNT_W-1:0] load_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= MDU_IDLE;
      count_reg <= '0;
      pend_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      pend_reg  <= pend_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    pend_next  = 1'b0;
    load_val   = is_div ? DIV_LOAD : MUL_LOAD;

    if (state_reg == MDU_BUSY) begin
      if (count_reg == '0) begin
        state_next = MDU_IDLE;
      end else begin
        count_next = count_reg - 1'b1;
      end
    end

    // A start (even an illegal one while BUSY) reloads the timer.
    if (start) begin
      count_next = load_val;
      if (load_val == '0) begin
        state_next = MDU_IDLE;
        pend_next  = 1'b1;
      end else begin
        state_next = MDU_BUSY;
      end
    end
  end

  assign busy = (state_reg == MDU_BUSY);
  assign done = (busy && (count_reg == '0)) || pend_reg;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard and sequencing controller for the 5-stage MIPS pipeline.
// Inputs : id_rs/id_rt/id_uses_rs/id_uses_rt/id_mdu_use/id_redirect (ID),
//          ex_mem_read/ex_rt_dest/ex_mdu_start/ex_mdu_is_div (EX),
//          imem_ready (IF), mem_access/dmem_ready (MEM)
// Outputs: pc_en, if_id_stall/flush, id_ex_stall/flush, ex_mem_stall,
//          mem_wb_flush, mdu_busy, mdu_done
// Optional: define PIPE_CTRL_PERF_EN to add perf_stall_cyc (cycles with
//           pc_en=0) and perf_flush_cnt (cycles with if_id_flush=1).
// Priority (first match wins): data-memory wait, ID hazard (load-use or
// MDU busy), redirect, fetch wait. All outputs are forced low in reset.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_MUL_CYC = MDU_MUL_CYC_DEF,
  parameter int MDU_DIV_CYC = MDU_DIV_CYC_DEF,
  parameter int CNT_W       = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_mdu_use,
  input  logic       id_redirect,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt_dest,
  input  logic       ex_mdu_start,
  input  logic       ex_mdu_is_div,
  input  logic       imem_ready,
  input  logic       mem_access,
  input  logic       dmem_ready,
  output logic       pc_en,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_ex_stall,
  output logic       id_ex_flush,
  output logic       ex_mem_stall,
  output logic       mem_wb_flush,
  output logic       mdu_busy,
  output logic       mdu_done
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cnt
`endif
);

  logic dmem_wait, load_use, mdu_hazard;
  logic timer_busy, timer_done, timer_start;
  logic pc_en_c, if_id_stall_c, if_id_flush_c, id_ex_stall_c, id_ex_flush_c;
  logic ex_mem_stall_c, mem_wb_flush_c;

  assign dmem_wait  = mem_access && !dmem_ready;
  assign load_use   = ex_mem_read && (ex_rt_dest != REG_ZERO) &&
                      (reg_hit(id_uses_rs, id_rs, ex_rt_dest) ||
                       reg_hit(id_uses_rt, id_rt, ex_rt_dest));
  // On the final MDU cycle the result is ready, so the waiting instruction
  // may leave ID.
  assign mdu_hazard = timer_busy && id_mdu_use && !timer_done;

  always_comb begin
    pc_en_c        = 1'b1;
    if_id_stall_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_stall_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    ex_mem_stall_c = 1'b0;
    mem_wb_flush_c = 1'b0;
    if (dmem_wait) begin
      // Freeze everything up to MEM; a redirect is retried next cycle.
      pc_en_c        = 1'b0;
      if_id_stall_c  = 1'b1;
      id_ex_stall_c  = 1'b1;
      ex_mem_stall_c = 1'b1;
      mem_wb_flush_c = 1'b1;
    end else if (load_use || mdu_hazard) begin
      pc_en_c       = 1'b0;
      if_id_stall_c = 1'b1;
      id_ex_flush_c = 1'b1;
    end else if (id_redirect) begin
      // The fetch in flight is wrong-path: drop it whether or not it is ready.
      if_id_flush_c = 1'b1;
    end else if (!imem_ready) begin
      pc_en_c       = 1'b0;
      if_id_flush_c = 1'b1;
    end
  end

  assign pc_en        = rst_n && pc_en_c;
  assign if_id_stall  = rst_n && if_id_stall_c;
  assign if_id_flush  = rst_n && if_id_flush_c;
  assign id_ex_stall  = rst_n && id_ex_stall_c;
  assign id_ex_flush  = rst_n && id_ex_flush_c;
  assign ex_mem_stall = rst_n && ex_mem_stall_c;
  assign mem_wb_flush = rst_n && mem_wb_flush_c;
  assign mdu_busy     = rst_n && timer_busy;
  assign mdu_done     = rst_n && timer_done;

  // An MDU op held in EX by a memory freeze starts once the freeze lifts.
  assign timer_start = ex_mdu_start && !ex_mem_stall_c;

  mdu_busy_timer #(
    .MUL_CYC (MDU_MUL_CYC),
    .DIV_CYC (MDU_DIV_CYC),
    .CNT_W   (CNT_W)
  ) u_mdu_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (timer_start),
    .is_div (ex_mdu_is_div),
    .busy   (timer_busy),
    .done   (timer_done)
  );

`ifdef PIPE_CTRL_PERF_EN
  // Index 0: stall cycles, index 1: IF_ID flush cycles.
  logic [1:0] perf_inc;
  assign perf_inc = {if_id_flush, !pc_en};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_perf
      logic [31:0] cnt_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (perf_inc[gi]) begin
          cnt_reg <= cnt_reg + 32'd1;
        end
      end
    end
  endgenerate

  assign perf_stall_cyc = g_perf[0].cnt_reg;
  assign perf_flush_cnt = g_perf[1].cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed scenarios followed by randomized traffic, every cycle compared
// against a reference model. The model tracks an MDU op as "started in cycle
// s, finishes in cycle s+latency" and derives controls from the priority
// table. Output vector order: pc_en, if_id_stall, if_id_flush, id_ex_stall,
// id_ex_flush, ex_mem_stall, mem_wb_flush, mdu_busy, mdu_done.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int MUL_L = 4;
  localparam int DIV_L = 32;

  logic       clk, rst_n;
  logic [4:0] id_rs, id_rt, ex_rt_dest;
  logic       id_uses_rs, id_uses_rt, id_mdu_use, id_redirect;
  logic       ex_mem_read, ex_mdu_start, ex_mdu_is_div;
  logic       imem_ready, mem_access, dmem_ready;
  logic       pc_en, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic       ex_mem_stall, mem_wb_flush, mdu_busy, mdu_done;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt;
`endif

  pipe_hazard_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rs    (id_uses_rs),
    .id_uses_rt    (id_uses_rt),
    .id_mdu_use    (id_mdu_use),
    .id_redirect   (id_redirect),
    .ex_mem_read   (ex_mem_read),
    .ex_rt_dest    (ex_rt_dest),
    .ex_mdu_start  (ex_mdu_start),
    .ex_mdu_is_div (ex_mdu_is_div),
    .imem_ready    (imem_ready),
    .mem_access    (mem_access),
    .dmem_ready    (dmem_ready),
    .pc_en         (pc_en),
    .if_id_stall   (if_id_stall),
    .if_id_flush   (if_id_flush),
    .id_ex_stall   (id_ex_stall),
    .id_ex_flush   (id_ex_flush),
    .ex_mem_stall  (ex_mem_stall),
    .mem_wb_flush  (mem_wb_flush),
    .mdu_busy      (mdu_busy),
    .mdu_done      (mdu_done)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cyc(perf_stall_cyc),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_txn = 0;
  int          cyc = 0;
  int          start_cyc = -1000;
  int          done_cyc  = -1000;
  logic [31:0] m_stall_cnt = '0;
  logic [31:0] m_flush_cnt = '0;
  logic [8:0]  obs;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [8:0] dut_outs();
    return {pc_en, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
            ex_mem_stall, mem_wb_flush, mdu_busy, mdu_done};
  endfunction

  // MDU op started in cycle s with latency L is busy in cycles s+1..s+L
  // (only when L > 1) and finishes in cycle s+L.
  function automatic logic m_busy();
    return (cyc > start_cyc) && (cyc <= done_cyc) && (done_cyc - start_cyc > 1);
  endfunction

  function automatic logic m_done();
    return cyc == done_cyc;
  endfunction

  function automatic logic [8:0] model_outs();
    logic [6:0] ctl;
    logic       hit;
    if (!rst_n) return '0;
    hit = ex_mem_read && (ex_rt_dest != 5'd0) &&
          ((id_uses_rs && id_rs == ex_rt_dest) || (id_uses_rt && id_rt == ex_rt_dest));
    if (mem_access && !dmem_ready)                   ctl = 7'b0101011;
    else if (hit || (m_busy() && id_mdu_use && !m_done())) ctl = 7'b0100100;
    else if (id_redirect)                            ctl = 7'b1010000;
    else if (!imem_ready)                            ctl = 7'b0010000;
    else                                             ctl = 7'b1000000;
    return {ctl, m_busy(), m_done()};
  endfunction

  task automatic model_reset();
    start_cyc   = -1000;
    done_cyc    = -1000;
    m_stall_cnt = '0;
    m_flush_cnt = '0;
  endtask

  task automatic set_idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt_dest = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_mdu_use = 1'b0; id_redirect = 1'b0;
    ex_mem_read = 1'b0; ex_mdu_start = 1'b0; ex_mdu_is_div = 1'b0;
    imem_ready = 1'b1; mem_access = 1'b0; dmem_ready = 1'b1;
  endtask

  // One clock cycle: compare at the falling edge, advance the model at the
  // rising edge, return 1 time unit after it.
  task automatic tick();
    logic [8:0] exp;
    assert (!(rst_n && ex_mdu_start && m_busy()))
      else $error("MDU start issued while MDU busy (cycle %0d)", cyc);
    @(negedge clk);
    exp = model_outs();
    obs = dut_outs();
    check_eq("outs", {23'd0, obs}, {23'd0, exp});
`ifdef PIPE_CTRL_PERF_EN
    check_eq("perf_stall", perf_stall_cyc, m_stall_cnt);
    check_eq("perf_flush", perf_flush_cnt, m_flush_cnt);
`endif
    n_txn++;
    $display("txn %0d cyc=%0d rst_n=%b ma=%b dr=%b ir=%b rd=%b lu=%b/%0d mdu=%b/%b/%b out=%b",
             n_txn, cyc, rst_n, mem_access, dmem_ready, imem_ready, id_redirect,
             ex_mem_read, ex_rt_dest, ex_mdu_start, ex_mdu_is_div, id_mdu_use, obs);
    @(posedge clk);
    if (rst_n) begin
      if (ex_mdu_start && !exp[3]) begin
        start_cyc = cyc;
        done_cyc  = cyc + (ex_mdu_is_div ? DIV_L : MUL_L);
      end
      if (!exp[8]) m_stall_cnt = m_stall_cnt + 32'd1;
      if (exp[6])  m_flush_cnt = m_flush_cnt + 32'd1;
    end
    cyc++;
    #1;
  endtask

  initial begin
    int busy_n, stall_n, done_at, frz_n;
    set_idle();
    rst_n = 1'b0;
    #1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Load-use: lw $t0 in EX, add $t1,$t0,$t2 in ID.
    ex_mem_read = 1'b1; ex_rt_dest = 5'd8; id_uses_rs = 1'b1; id_rs = 5'd8;
    id_uses_rt = 1'b1; id_rt = 5'd10;
    tick();
    check_eq("loaduse_ctl", {29'd0, obs[8], obs[7], obs[4]}, 32'b011);
    ex_mem_read = 1'b0;
    tick();
    check_eq("loaduse_release_pc_en", {31'd0, obs[8]}, 32'd1);

    // Load to $zero never stalls.
    ex_mem_read = 1'b1; ex_rt_dest = 5'd0; id_rs = 5'd0;
    tick();
    check_eq("load_zero_pc_en", {31'd0, obs[8]}, 32'd1);
    set_idle();

    // DIV then MFLO waiting in ID.
    ex_mdu_start = 1'b1; ex_mdu_is_div = 1'b1;
    tick();
    ex_mdu_start = 1'b0; ex_mdu_is_div = 1'b0; id_mdu_use = 1'b1;
    busy_n = 0; stall_n = 0; done_at = 0;
    for (int i = 1; i <= 34; i++) begin
      tick();
      if (obs[1]) busy_n++;
      if (!obs[8]) stall_n++;
      if (obs[0]) done_at = i;
    end
    check_eq("div_busy_cycles", busy_n, 32);
    check_eq("div_stall_cycles", stall_n, 31);
    check_eq("div_done_cycle", done_at, 32);
    set_idle();

    // Redirect with fetch not ready, then with a data-memory wait too.
    id_redirect = 1'b1; imem_ready = 1'b0;
    tick();
    check_eq("redirect_ctl", {30'd0, obs[8], obs[6]}, 32'b11);
    mem_access = 1'b1; dmem_ready = 1'b0;
    tick();
    check_eq("redirect_p1_ctl", {25'd0, obs[8:2]}, 32'b0101011);
    set_idle();

    // MULT with three data-memory wait cycles during busy.
    ex_mdu_start = 1'b1;
    tick();
    ex_mdu_start = 1'b0; mem_access = 1'b1; dmem_ready = 1'b0;
    frz_n = 0; done_at = 0;
    for (int i = 1; i <= 6; i++) begin
      if (i == 4) dmem_ready = 1'b1;
      tick();
      if (obs[2]) frz_n++;
      if (obs[0]) done_at = i;
    end
    check_eq("mult_freeze_cycles", frz_n, 3);
    check_eq("mult_done_cycle", done_at, 4);
    set_idle();

    // Asynchronous reset in the middle of a DIV (count 17).
    ex_mdu_start = 1'b1; ex_mdu_is_div = 1'b1;
    tick();
    ex_mdu_start = 1'b0; ex_mdu_is_div = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    mem_access = 1'b1; dmem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("async_reset_outs", {23'd0, dut_outs()}, 32'd0);
    tick();
    rst_n = 1'b1;
    set_idle();
    id_mdu_use = 1'b1;
    tick();
    check_eq("post_reset_busy", {31'd0, obs[1]}, 32'd0);
    set_idle();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      ex_rt_dest   = 5'($urandom_range(0, 3));
      id_uses_rs   = $urandom_range(0, 1) == 1;
      id_uses_rt   = $urandom_range(0, 1) == 1;
      ex_mem_read  = $urandom_range(0, 9) < 3;
      id_mdu_use   = $urandom_range(0, 9) < 3;
      id_redirect  = $urandom_range(0, 9) < 2;
      imem_ready   = $urandom_range(0, 9) < 8;
      mem_access   = $urandom_range(0, 9) < 3;
      dmem_ready   = $urandom_range(0, 9) < 6;
      ex_mdu_is_div = $urandom_range(0, 3) == 0;
      ex_mdu_start = !m_busy() && ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
